iob_spi_fl_arbiter: RTL and testbench
=====================================

# iob_spi_fl_arbiter

Arbiter and sequencer in front of the `spi_master_fl` flash core inside the SPI peripheral. It shares the core between two requesters: the read-only cache port and the software register port (FL_* registers). For each granted request it latches the command, address and data, pulses the core's `validflag`, and tracks the core through its busy/done phases. It then returns read data and a one-cycle ready to the owner.

## Interface
- `DATA_W`, 32, data width of core and both requesters
- `CADDR_W`, 24, cache address width; zero-extended to 32 bits
- `TIMEOUT_W`, 16, watchdog counter width; used only with the timeout macro
- `clk_i`  in  1  clock
- `arst_i`  in  1  reset: asynchronous, active-high; clock is `clk_i`
- `soft_rst_i`  in  1  synchronous reset, driven by FL_RESET
- `c_valid_i`  in  1  cache read request; held until `c_ready_o`
- `c_addr_i`  in  CADDR_W  cache read address
- `c_cmd_i`  in  32  static cache read command word, FL_COMMAND format
- `c_cmdtp_i`  in  32  static cache command type, FL_COMMANDTP format
- `c_ready_o`  out  1  one-cycle completion pulse; `c_rdata_o` valid in that cycle
- `c_rdata_o`  out  DATA_W  cache read data
- `s_valid_i`  in  1  software request, level (FL_VALIDFLG); held until `s_ready_o`
- `s_addr_i`, `s_cmd_i`, `s_cmdtp_i`  in  32 each  FL_ADDRESS, FL_COMMAND, FL_COMMANDTP
- `s_datain_i`  in  DATA_W  FL_DATAIN
- `s_ready_o`  out  1  one-cycle completion pulse
- `s_rdata_o`  out  DATA_W  FL_DATAOUT
- `fl_validflag_o`  out  1  core start pulse
- `fl_address_o`, `fl_command_o`, `fl_commandtp_o`  out  32 each  latched request fields sent to the core
- `fl_datain_o`  out  DATA_W  latched write data sent to the core
- `fl_dataout_i`  in  DATA_W  core read data
- `fl_tready_i`  in  1  core idle/done: high = idle
- `busy_o`  out  1  high whenever state ≠ IDLE
- `owner_o`  out  1  current or last grant: 0 = cache, 1 = software
- `timeout_o`  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE → ISSUE when any valid is high and `fl_tready_i`=1.
  - On this transition the arbiter latches the winner's fields and sets `owner_o`.
  - Cache address is zero-extended to 32 bits. For the cache, `fl_datain_o` is 0.
- Arbitration is round-robin. When both valids are high, grant the requester that is not `owner_o`. After reset, `owner_o`=1, so the cache wins the first tie.
- ISSUE: `fl_validflag_o`=1 for exactly one cycle, then → WAIT_BUSY.
- WAIT_BUSY: stay until `fl_tready_i`=0, then → WAIT_DONE.
- WAIT_DONE: stay until `fl_tready_i`=1. On that edge, capture `fl_dataout_i` into the owner's rdata register and → RESP.
- RESP: the owner's ready is 1 for one cycle, then → IDLE.
  - IDLE evaluates arbitration again in the following cycle.
  - A requester whose valid is still high is treated as a new request.
- The `fl_*` field outputs hold their latched values from ISSUE until the next grant.
- The non-owner's ready stays 0. Its rdata register keeps its previous value.
- Valid dropped mid-transaction: the transaction still completes and the ready pulse is still issued.
- `soft_rst_i` in any state: FSM → IDLE next cycle and all outputs return to reset values. No ready is issued for the aborted request; a held valid is re-arbitrated.

## Timing
- Reset values (both resets): state IDLE; `c_ready_o`, `s_ready_o`, `fl_validflag_o`, `busy_o`, `timeout_o` = 0; `owner_o`=1; all data, address and command outputs = 0.
- Valid sampled in IDLE at cycle N:
  - `fl_validflag_o` high at N+1.
  - If tready falls at N+2 and rises at N+2+T, ready is high at N+3+T. Minimum request-to-ready latency is T+3.
- Ready to the next grant: the ISSUE pulse comes at the earliest 2 cycles after the ready pulse.
- Back-to-back requests from alternating requesters never issue two ISSUE pulses closer than 4 cycles apart.

## Configuration
- `SPI_FL_ARB_TIMEOUT_EN` defined:
  - A TIMEOUT_W-bit counter clears at ISSUE and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches all-ones: → RESP, owner rdata = all-ones, `timeout_o` set.
  - `timeout_o` clears at the next grant or on reset.
- Not defined: no counter is instantiated, `timeout_o` is tied to 0, and the wait states wait indefinitely.

## Test plan
- Cache-only read: `c_addr_i`=0x000100, core model busy 10 cycles returning 0xA5A55A5A → `fl_address_o`=0x00000100, one `fl_validflag_o` pulse, `c_ready_o` 13 cycles after the request, `c_rdata_o`=0xA5A55A5A.
- Simultaneous `c_valid_i`/`s_valid_i` from reset → cache served first, then software. Owner sequence 0,1. Each ready is exactly one cycle.
- Software held valid for 3 consecutive transactions while cache also requests → grants strictly alternate 0,1,0,1.
- `soft_rst_i` asserted in WAIT_DONE → `busy_o`=0 next cycle, no ready pulse; held valid is re-issued with a new `fl_validflag_o`.
- With `SPI_FL_ARB_TIMEOUT_EN` and TIMEOUT_W=4, core never returns tready → RESP after 15 wait cycles, `s_rdata_o`=0xFFFFFFFF, `timeout_o`=1, cleared at the next grant.
- Core tready low at request time → no ISSUE until `fl_tready_i`=1; fields are not latched early.

Source files
------------

// File: rtl/iob_spi_fl_arbiter.sv
// Round-robin arbiter/sequencer sharing the spi_master_fl core between the cache read port and FL_* registers.
// Optional watchdog enabled by defining SPI_FL_ARB_TIMEOUT_EN.
module iob_spi_fl_arbiter #(
  parameter int DATA_W    = 32,
  parameter int CADDR_W   = 24,
  parameter int TIMEOUT_W = 16
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              soft_rst_i,
  input  logic              c_valid_i,
  input  logic [CADDR_W-1:0] c_addr_i,
  input  logic [31:0]       c_cmd_i,
  input  logic [31:0]       c_cmdtp_i,
  output logic              c_ready_o,
  output logic [DATA_W-1:0] c_rdata_o,
  input  logic              s_valid_i,
  input  logic [31:0]       s_addr_i,
  input  logic [31:0]       s_cmd_i,
  input  logic [31:0]       s_cmdtp_i,
  input  logic [DATA_W-1:0] s_datain_i,
  output logic              s_ready_o,
  output logic [DATA_W-1:0] s_rdata_o,
  output logic              fl_validflag_o,
  output logic [31:0]       fl_address_o,
  output logic [31:0]       fl_command_o,
  output logic [31:0]       fl_commandtp_o,
  output logic [DATA_W-1:0] fl_datain_o,
  input  logic [DATA_W-1:0] fl_dataout_i,
  input  logic              fl_tready_i,
  output logic              busy_o,
  output logic              owner_o,
  output logic              timeout_o
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       cmd_q, cmd_d;
  logic [31:0]       cmdtp_q, cmdtp_d;
  logic [DATA_W-1:0] datain_q, datain_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] s_rdata_q, s_rdata_d;
  logic              grant_s;

  // On a tie the requester that did not hold the core last wins.
  assign grant_s = s_valid_i & (~c_valid_i | ~owner_q);

`ifdef SPI_FL_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic                 timeout_q, timeout_d;

  assign tcnt_inc  = tcnt_q + TIMEOUT_W'(1);
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    cmdtp_d   = cmdtp_q;
    datain_d  = datain_q;
    c_rdata_d = c_rdata_q;
    s_rdata_d = s_rdata_q;
`ifdef SPI_FL_ARB_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      IDLE: begin
        if ((c_valid_i | s_valid_i) & fl_tready_i) begin
          state_d = ISSUE;
          owner_d = grant_s;
          if (grant_s) begin
            addr_d   = s_addr_i;
            cmd_d    = s_cmd_i;
            cmdtp_d  = s_cmdtp_i;
            datain_d = s_datain_i;
          end else begin
            addr_d   = 32'(c_addr_i);
            cmd_d    = c_cmd_i;
            cmdtp_d  = c_cmdtp_i;
            datain_d = '0;
          end
`ifdef SPI_FL_ARB_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
`ifdef SPI_FL_ARB_TIMEOUT_EN
        tcnt_d = '0;
`endif
      end
      WAIT_BUSY: begin
        if (!fl_tready_i) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (fl_tready_i) begin
          state_d = RESP;
          if (owner_q) s_rdata_d = fl_dataout_i;
          else         c_rdata_d = fl_dataout_i;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef SPI_FL_ARB_TIMEOUT_EN
    // A normal completion in the same cycle wins over the watchdog.
    if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
      tcnt_d = tcnt_inc;
      if ((&tcnt_inc) && state_d != RESP) begin
        state_d   = RESP;
        timeout_d = 1'b1;
        if (owner_q) s_rdata_d = '1;
        else         c_rdata_d = '1;
      end
    end
`endif

    if (soft_rst_i) begin
      state_d   = IDLE;
      owner_d   = 1'b1;
      addr_d    = '0;
      cmd_d     = '0;
      cmdtp_d   = '0;
      datain_d  = '0;
      c_rdata_d = '0;
      s_rdata_d = '0;
`ifdef SPI_FL_ARB_TIMEOUT_EN
      tcnt_d    = '0;
      timeout_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      owner_q   <= 1'b1;
      addr_q    <= '0;
      cmd_q     <= '0;
      cmdtp_q   <= '0;
      datain_q  <= '0;
      c_rdata_q <= '0;
      s_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      cmdtp_q   <= cmdtp_d;
      datain_q  <= datain_d;
      c_rdata_q <= c_rdata_d;
      s_rdata_q <= s_rdata_d;
    end
  end

`ifdef SPI_FL_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign fl_validflag_o = (state_q == ISSUE);
  assign busy_o         = (state_q != IDLE);
  assign c_ready_o      = (state_q == RESP) & ~owner_q;
  assign s_ready_o      = (state_q == RESP) & owner_q;
  assign owner_o        = owner_q;
  assign fl_address_o   = addr_q;
  assign fl_command_o   = cmd_q;
  assign fl_commandtp_o = cmdtp_q;
  assign fl_datain_o    = datain_q;
  assign c_rdata_o      = c_rdata_q;
  assign s_rdata_o      = s_rdata_q;

endmodule

// File: tb/tb_iob_spi_fl_arbiter.sv
// Self-checking bench for iob_spi_fl_arbiter: vector table, randomized transactions vs. a
// transaction-level model, and hand sequences for soft reset, tready-low, alternation and watchdog.
module tb_iob_spi_fl_arbiter;

  logic        clk_i = 1'b0;
  logic        arst_i, soft_rst_i;
  logic        c_valid_i;
  logic [23:0] c_addr_i;
  logic [31:0] c_cmd_i, c_cmdtp_i;
  logic        c_ready_o;
  logic [31:0] c_rdata_o;
  logic        s_valid_i;
  logic [31:0] s_addr_i, s_cmd_i, s_cmdtp_i, s_datain_i;
  logic        s_ready_o;
  logic [31:0] s_rdata_o;
  logic        fl_validflag_o;
  logic [31:0] fl_address_o, fl_command_o, fl_commandtp_o, fl_datain_o;
  logic [31:0] fl_dataout_i;
  logic        fl_tready_i;
  logic        busy_o, owner_o, timeout_o;

  logic        core_rdy, ext_low;
  int          core_t;
  logic [31:0] core_data;

  assign fl_tready_i = core_rdy & ~ext_low;

  iob_spi_fl_arbiter #(.DATA_W(32), .CADDR_W(24), .TIMEOUT_W(4)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .soft_rst_i(soft_rst_i),
    .c_valid_i(c_valid_i), .c_addr_i(c_addr_i), .c_cmd_i(c_cmd_i), .c_cmdtp_i(c_cmdtp_i),
    .c_ready_o(c_ready_o), .c_rdata_o(c_rdata_o),
    .s_valid_i(s_valid_i), .s_addr_i(s_addr_i), .s_cmd_i(s_cmd_i), .s_cmdtp_i(s_cmdtp_i),
    .s_datain_i(s_datain_i), .s_ready_o(s_ready_o), .s_rdata_o(s_rdata_o),
    .fl_validflag_o(fl_validflag_o), .fl_address_o(fl_address_o), .fl_command_o(fl_command_o),
    .fl_commandtp_o(fl_commandtp_o), .fl_datain_o(fl_datain_o), .fl_dataout_i(fl_dataout_i),
    .fl_tready_i(fl_tready_i), .busy_o(busy_o), .owner_o(owner_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Event log sampled mid-cycle
  int cyc = 0;
  int vf_q[$];
  int rdy_q[$];
  bit own_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (fl_validflag_o) vf_q.push_back(cyc);
    if (c_ready_o) begin rdy_q.push_back(cyc); own_q.push_back(1'b0); end
    if (s_ready_o) begin rdy_q.push_back(cyc); own_q.push_back(1'b1); end
  end

  // Core model: busy for core_t cycles starting the cycle after the start pulse
  initial begin
    core_rdy = 1'b1;
    fl_dataout_i = '0;
    forever begin
      @(negedge clk_i);
      if (fl_validflag_o) begin
        @(posedge clk_i); #1;
        core_rdy = 1'b0;
        fl_dataout_i = ~core_data;
        repeat (core_t) @(posedge clk_i);
        #1;
        core_rdy = 1'b1;
        fl_dataout_i = core_data;
      end
    end
  end

  int total = 0, bad = 0;
  bit          m_owner;
  logic [31:0] m_c_rdata, m_s_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic clr_log();
    vf_q.delete(); rdy_q.delete(); own_q.delete();
  endtask

  task automatic do_arst();
    arst_i = 1'b1; soft_rst_i = 1'b0; c_valid_i = 1'b0; s_valid_i = 1'b0; ext_low = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 arst_i = 1'b0;
    m_owner = 1'b1; m_c_rdata = '0; m_s_rdata = '0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".busy"}, busy_o, 0);
    chk({nm, ".owner"}, owner_o, 1);
    chk({nm, ".c_ready"}, c_ready_o, 0);
    chk({nm, ".s_ready"}, s_ready_o, 0);
    chk({nm, ".vf"}, fl_validflag_o, 0);
    chk({nm, ".addr"}, fl_address_o, 0);
    chk({nm, ".cmd"}, fl_command_o, 0);
    chk({nm, ".cmdtp"}, fl_commandtp_o, 0);
    chk({nm, ".din"}, fl_datain_o, 0);
    chk({nm, ".c_rdata"}, c_rdata_o, 0);
    chk({nm, ".s_rdata"}, s_rdata_o, 0);
    chk({nm, ".timeout"}, timeout_o, 0);
  endtask

  // One request from IDLE through its ready pulse
  task automatic txn(input string nm, input bit cv, input bit sv, input logic [23:0] ca,
                     input logic [31:0] sa, input int t, input logic [31:0] d, input bit eo);
    int n, k;
    logic [31:0] ea, ecmd, etp, edin;
    @(posedge clk_i); #1;
    clr_log();
    core_t = t; core_data = d;
    c_addr_i = ca; s_addr_i = sa;
    c_cmd_i = $urandom; c_cmdtp_i = $urandom;
    s_cmd_i = $urandom; s_cmdtp_i = $urandom; s_datain_i = $urandom;
    ea   = eo ? sa : {8'h00, ca};
    ecmd = eo ? s_cmd_i : c_cmd_i;
    etp  = eo ? s_cmdtp_i : c_cmdtp_i;
    edin = eo ? s_datain_i : 32'h0;
    c_valid_i = cv; s_valid_i = sv; n = cyc;
    k = 0;
    while (rdy_q.size() == 0 && k < 200) begin @(negedge clk_i); #1; k++; end
    if (rdy_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s.wait: no ready within 200 cycles", nm);
      c_valid_i = 1'b0; s_valid_i = 1'b0;
      return;
    end
    chk({nm, ".own"}, own_q[0], eo);
    chk({nm, ".owner_o"}, owner_o, eo);
    chk({nm, ".lat"}, rdy_q[0] - n, t + 3);
    chk({nm, ".vf_n"}, vf_q.size(), 1);
    if (vf_q.size() > 0) chk({nm, ".vf_at"}, vf_q[0] - n, 1);
    chk({nm, ".addr"}, fl_address_o, ea);
    chk({nm, ".cmd"}, fl_command_o, ecmd);
    chk({nm, ".cmdtp"}, fl_commandtp_o, etp);
    chk({nm, ".din"}, fl_datain_o, edin);
    chk({nm, ".rdata"}, eo ? s_rdata_o : c_rdata_o, d);
    chk({nm, ".keep"}, eo ? c_rdata_o : s_rdata_o, eo ? m_c_rdata : m_s_rdata);
    m_owner = eo;
    if (eo) m_s_rdata = d; else m_c_rdata = d;
    @(posedge clk_i); #1;
    c_valid_i = 1'b0; s_valid_i = 1'b0;
    @(negedge clk_i); #1;
    chk({nm, ".pulse1"}, rdy_q.size(), 1);
  endtask

  typedef struct {
    bit          cv;
    bit          sv;
    logic [23:0] ca;
    logic [31:0] sa;
    int          t;
    logic [31:0] d;
    bit          eo;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n, k, r;
    c_addr_i = '0; c_cmd_i = '0; c_cmdtp_i = '0;
    s_addr_i = '0; s_cmd_i = '0; s_cmdtp_i = '0; s_datain_i = '0;
    core_t = 1; core_data = '0;

    tbl[0] = '{1'b1, 1'b0, 24'h000100, 32'h0,        10, 32'hA5A55A5A, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 24'h123456, 32'hDEADBEEF, 3,  32'h01234567, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 24'hABCDEF, 32'h11111111, 1,  32'h89ABCDEF, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 24'h000000, 32'h00000040, 5,  32'h5A5A0000, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 24'h000000, 32'h00000080, 2,  32'h0000FFFF, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 24'hFFFFFF, 32'h22222222, 4,  32'hCAFEF00D, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 24'h000001, 32'h33333333, 1,  32'h00000000, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 24'h000002, 32'h44444444, 2,  32'hFFFFFFFF, 1'b1};

    do_arst();
    chk_reset("reset");

    for (int i = 0; i < 8; i++)
      txn($sformatf("vec%0d", i), tbl[i].cv, tbl[i].sv, tbl[i].ca, tbl[i].sa, tbl[i].t, tbl[i].d, tbl[i].eo);

    // Randomized requests against the round-robin rule
    for (int i = 0; i < 30; i++) begin
      bit cv, sv, eo;
      r  = $urandom_range(1, 3);
      cv = r[0]; sv = r[1];
      eo = (cv && sv) ? !m_owner : sv;
      txn($sformatf("rnd%0d", i), cv, sv, 24'($urandom), $urandom, $urandom_range(1, 6), $urandom, eo);
    end

    // Soft reset while waiting for the core to finish
    @(posedge clk_i); #1;
    clr_log();
    core_t = 10; core_data = 32'h0F0F1234; c_addr_i = 24'h000200; c_valid_i = 1'b1; n = cyc;
    repeat (5) @(posedge clk_i);
    #1 soft_rst_i = 1'b1;
    @(posedge clk_i); #1;
    soft_rst_i = 1'b0;
    chk("srst.busy", busy_o, 0);
    chk("srst.owner", owner_o, 1);
    chk("srst.addr", fl_address_o, 0);
    chk("srst.c_rdata", c_rdata_o, 0);
    chk("srst.s_rdata", s_rdata_o, 0);
    k = 0;
    while (rdy_q.size() == 0 && k < 200) begin @(negedge clk_i); #1; k++; end
    chk("srst.vf_n", vf_q.size(), 2);
    chk("srst.rdy_n", rdy_q.size(), 1);
    if (vf_q.size() == 2 && rdy_q.size() == 1) begin
      chk("srst.reissue_at", vf_q[1] - n, 13);
      chk("srst.lat", rdy_q[0] - vf_q[1], 12);
      chk("srst.own", own_q[0], 0);
    end
    chk("srst.rdata", c_rdata_o, 32'h0F0F1234);
    @(posedge clk_i); #1;
    c_valid_i = 1'b0;
    m_owner = 1'b0; m_c_rdata = 32'h0F0F1234; m_s_rdata = '0;

    // Core not idle when request arrives: nothing latched until tready returns
    @(posedge clk_i); #1;
    clr_log();
    ext_low = 1'b1; core_t = 2; core_data = 32'h13572468;
    s_addr_i = 32'h00ABC000; s_valid_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    chk("trdy.vf_n", vf_q.size(), 0);
    chk("trdy.busy", busy_o, 0);
    chk("trdy.addr_hold", fl_address_o, 32'h00000200);
    r = cyc;
    ext_low = 1'b0;
    k = 0;
    while (rdy_q.size() == 0 && k < 200) begin @(negedge clk_i); #1; k++; end
    chk("trdy.rdy_n", rdy_q.size(), 1);
    if (vf_q.size() > 0 && rdy_q.size() > 0) begin
      chk("trdy.vf_at", vf_q[0] - r, 1);
      chk("trdy.lat", rdy_q[0] - r, 5);
    end
    chk("trdy.addr", fl_address_o, 32'h00ABC000);
    chk("trdy.rdata", s_rdata_o, 32'h13572468);
    @(posedge clk_i); #1;
    s_valid_i = 1'b0;

    // Both requesters held from reset: strict alternation, cache first
    do_arst();
    chk_reset("reset2");
    clr_log();
    core_t = 2; core_data = 32'h600DF00D;
    c_addr_i = 24'h000010; s_addr_i = 32'h20;
    c_valid_i = 1'b1; s_valid_i = 1'b1;
    k = 0;
    while (own_q.size() < 4 && k < 300) begin @(negedge clk_i); #1; k++; end
    c_valid_i = 1'b0; s_valid_i = 1'b0;
    if (own_q.size() < 4 || vf_q.size() < 4) begin
      total++; bad++;
      $display("FAIL alt.wait: got %0d readies, required 4", own_q.size());
    end else begin
      for (int i = 0; i < 4; i++) chk($sformatf("alt.own%0d", i), own_q[i], i % 2);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("alt.gap%0d", i), (vf_q[i + 1] - vf_q[i]) >= 4, 1);
        chk($sformatf("alt.rdy2vf%0d", i), vf_q[i + 1] - rdy_q[i], 2);
      end
    end
    repeat (2) @(posedge clk_i);
    #1;
    m_owner = 1'b1; m_c_rdata = 32'h600DF00D; m_s_rdata = 32'h600DF00D;

`ifdef SPI_FL_ARB_TIMEOUT_EN
    // Core stays busy far longer than the 4-bit watchdog allows
    clr_log();
    core_t = 60; core_data = 32'h12345678; s_valid_i = 1'b1; n = cyc;
    k = 0;
    while (rdy_q.size() == 0 && k < 100) begin @(negedge clk_i); #1; k++; end
    chk("tmo.rdy_n", rdy_q.size(), 1);
    if (rdy_q.size() > 0) chk("tmo.lat", rdy_q[0] - n, 17);
    chk("tmo.rdata", s_rdata_o, 32'hFFFFFFFF);
    chk("tmo.flag", timeout_o, 1);
    @(posedge clk_i); #1;
    s_valid_i = 1'b0;
    k = 0;
    while (!fl_tready_i && k < 100) begin @(posedge clk_i); #1; k++; end
    chk("tmo.sticky", timeout_o, 1);
    m_s_rdata = 32'hFFFFFFFF;
    txn("tmo.next", 1'b1, 1'b0, 24'h000300, 32'h0, 2, 32'h0BADCAFE, 1'b0);
    chk("tmo.cleared", timeout_o, 0);
`else
    chk("tmo.off", timeout_o, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
